// File: rtl/i2c_master.sv
// Byte-level I2C master sequencer: START/STOP/WRITE/READ commands to open-drain SCL/SDA controls.
// Define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL during the high phase.
module i2c_master #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o
);

    typedef enum logic [1:0] {StIdle, StStart, StStop, StBit} state_e;

    localparam logic [1:0]  CmdStart = 2'd0;
    localparam logic [1:0]  CmdStop  = 2'd1;
    localparam logic [1:0]  CmdRead  = 2'd3;
    localparam logic [15:0] CntMax   = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        nack_q, nack_d;
    logic        read_q, read_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic [1:0]  sda_s_q;
    logic        sda_sync;
    logic        quarter_end;
    logic        stretch_hold;
    logic        advance;
    logic        out_bit;

    assign sda_sync    = sda_s_q[1];
    assign quarter_end = (cnt_q == CntMax);

`ifdef I2C_CLOCK_STRETCH_EN
    logic [1:0] scl_s_q;
    always_ff @(posedge clk) begin
        if (reset) scl_s_q <= 2'b11;
        else       scl_s_q <= {scl_s_q[0], scl_i};
    end
    // Freeze the start of the high phase until the slave lets SCL go high.
    assign stretch_hold = (state_q != StIdle) && (phase_q == 2'd1) && (cnt_q == 16'd0) &&
                          !scl_s_q[1];
`else
    logic unused_scl;
    assign unused_scl   = scl_i;
    assign stretch_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        nack_d  = nack_q;
        read_d  = read_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        valid_d = 1'b0;
        advance = 1'b0;
        if (state_q == StIdle) begin
            if (cmd_valid && ready_q) begin
                cnt_d   = 16'd0;
                phase_d = 2'd0;
                bit_d   = 4'd0;
                data_d  = cmd_data;
                nack_d  = cmd_nack;
                read_d  = (cmd == CmdRead);
                advance = 1'b1;
                unique case (cmd)
                    CmdStart: state_d = StStart;
                    CmdStop:  state_d = StStop;
                    default:  state_d = StBit;
                endcase
            end
        end else begin
            if (!stretch_hold) cnt_d = quarter_end ? 16'd0 : cnt_q + 16'd1;
            if (state_q == StBit && phase_q == 2'd2 && quarter_end) begin
                if (bit_q != 4'd8) rx_d = {rx_q[6:0], sda_sync};
                else if (!read_q)  ack_d = sda_sync;
            end
            if (quarter_end) begin
                phase_d = phase_q + 2'd1;
                advance = 1'b1;
                if (phase_q == 2'd3) begin
                    if (state_q == StBit && bit_q != 4'd8) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        if (state_q == StBit && read_q) rdata_d = rx_q;
                        state_d = StIdle;
                        valid_d = 1'b1;
                        advance = 1'b0;
                    end
                end
            end
        end
    end

    // Line levels for the phase being entered; IDLE keeps whatever was last driven.
    always_comb begin
        if (bit_d == 4'd8) out_bit = read_d ? nack_d : 1'b1;
        else               out_bit = read_d ? 1'b1 : data_d[3'd7 - bit_d[2:0]];
        scl_d = scl_q;
        sda_d = sda_q;
        if (advance) begin
            unique case (state_d)
                StStart: begin
                    scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                    sda_d = (phase_d == 2'd0) || (phase_d == 2'd1);
                end
                StStop: begin
                    scl_d = (phase_d != 2'd0);
                    sda_d = (phase_d == 2'd2) || (phase_d == 2'd3);
                end
                StBit: begin
                    scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                    sda_d = out_bit;
                end
                default: ;
            endcase
        end
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= 2'd0;
            cnt_q   <= 16'd0;
            bit_q   <= 4'd0;
            data_q  <= 8'h00;
            nack_q  <= 1'b0;
            read_q  <= 1'b0;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            ack_q   <= 1'b1;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            sda_s_q <= 2'b11;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            read_q  <= read_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            sda_s_q <= {sda_s_q[0], sda_i};
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = (state_q != StIdle);
    assign rsp_valid = valid_q;
    assign rsp_data  = rdata_q;
    assign rsp_ack   = ack_q;
    assign scl_o     = scl_q;
    assign sda_o     = sda_q;

endmodule
